// File: rtl/sync_fifo_pkg.sv
// Shared constants and pointer-width helper for the synchronous FIFO.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    // One extra pointer bit separates the full and empty cases when the low bits match.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: one synchronous write port, one registered read port with enable.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Storage is never cleared; only the output register returns to zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and registered full/empty flags.
// Optional occupancy output level_out is enabled by defining FIFO_LEVEL_EN.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_en_in,
    output logic                  full_out,
    input  logic                  read_en_in,
    output logic [DATA_WIDTH-1:0] data_out,
`ifdef FIFO_LEVEL_EN
    output logic [ADDR_WIDTH:0]   level_out,
`endif
    output logic                  empty_out
);

    localparam int PW = ptr_width(ADDR_WIDTH);

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_nxt;
    logic [PW-1:0] rptr_nxt;
    logic          wr_acc;
    logic          rd_acc;

    // Acceptance uses the registered flags, so each port is gated independently.
    assign wr_acc   = write_en_in && !full_out;
    assign rd_acc   = read_en_in && !empty_out;
    assign wptr_nxt = wr_acc ? wptr + PW'(1) : wptr;
    assign rptr_nxt = rd_acc ? rptr + PW'(1) : rptr;

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .clr     (rst),
        .wr_en   (wr_acc && !rst),
        .wr_addr (wptr[ADDR_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rptr[ADDR_WIDTH-1:0]),
        .rd_data (data_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            empty_out <= 1'b1;
            full_out  <= 1'b0;
        end else begin
            wptr      <= wptr_nxt;
            rptr      <= rptr_nxt;
            empty_out <= (wptr_nxt == rptr_nxt);
            full_out  <= (wptr_nxt[ADDR_WIDTH] != rptr_nxt[ADDR_WIDTH]) &&
                         (wptr_nxt[ADDR_WIDTH-1:0] == rptr_nxt[ADDR_WIDTH-1:0]);
        end
    end

`ifdef FIFO_LEVEL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            level_out <= '0;
        end else begin
            level_out <= wptr_nxt - rptr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with a queue-based reference model compared every cycle.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          write_en_in = 1'b0;
    logic          read_en_in = 1'b0;
    logic          full_out;
    logic          empty_out;
    logic [DW-1:0] data_out;
`ifdef FIFO_LEVEL_EN
    logic [AW:0]   level_out;
`endif

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    // Reference model: a plain queue plus the last word popped.
    logic [DW-1:0] q [$];
    logic [DW-1:0] m_dout = '0;

    sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .write_en_in (write_en_in),
        .full_out    (full_out),
        .read_en_in  (read_en_in),
        .data_out    (data_out),
`ifdef FIFO_LEVEL_EN
        .level_out   (level_out),
`endif
        .empty_out   (empty_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bit do_wr;
        bit do_rd;
        if (rst) begin
            q.delete();
            m_dout = '0;
        end else begin
            do_wr = write_en_in && (q.size() < DEPTH);
            do_rd = read_en_in && (q.size() > 0);
            if (do_rd) m_dout = q.pop_front();
            if (do_wr) q.push_back(data_in);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("model_data", 32'(data_out), 32'(m_dout));
            chk("model_empty", 32'(empty_out), 32'(q.size() == 0));
            chk("model_full", 32'(full_out), 32'(q.size() == DEPTH));
`ifdef FIFO_LEVEL_EN
            chk("model_level", 32'(level_out), 32'(q.size()));
`endif
        end
    end

    task automatic cyc(input bit we, input logic [DW-1:0] din, input bit re);
        @(negedge clk);
        write_en_in = we;
        data_in     = din;
        read_en_in  = re;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        armed = 1'b1;
        chk("rst_empty", 32'(empty_out), 32'd1);
        chk("rst_full", 32'(full_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'h00);

        cyc(1'b1, 8'hAA, 1'b0);
        chk("simple_wr_empty", 32'(empty_out), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("simple_rd_data", 32'(data_out), 32'hAA);
        chk("simple_rd_empty", 32'(empty_out), 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, DW'(i), 1'b0);
            chk("fill_full", 32'(full_out), 32'(i == DEPTH - 1));
        end
        cyc(1'b1, 8'h55, 1'b0);
        chk("ovf_full", 32'(full_out), 32'd1);
        chk("ovf_data_hold", 32'(data_out), 32'hAA);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(data_out), 32'(i));
            chk("drain_full", 32'(full_out), 32'd0);
            chk("drain_empty", 32'(empty_out), 32'(i == DEPTH - 1));
        end
        cyc(1'b0, 8'h00, 1'b1);
        chk("udf_data_hold", 32'(data_out), 32'h0F);
        chk("udf_empty", 32'(empty_out), 32'd1);

        cyc(1'b1, 8'h77, 1'b1);
        chk("empty_rw_data", 32'(data_out), 32'h0F);
        chk("empty_rw_empty", 32'(empty_out), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("empty_rw_pop", 32'(data_out), 32'h77);

        cyc(1'b1, 8'h10, 1'b0);
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h12, 1'b0);
        cyc(1'b1, 8'h13, 1'b1);
        chk("simul_oldest", 32'(data_out), 32'h10);
        chk("simul_empty", 32'(empty_out), 32'd0);
`ifdef FIFO_LEVEL_EN
        chk("simul_level", 32'(level_out), 32'd3);
`endif
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, DW'(8'h20 + i), 1'b1);
            chk("pair_data", 32'(data_out), (i < 3) ? 32'(8'h11 + i) : 32'(8'h20 + i - 3));
        end

        // Fill to full, then read+write together: only the read is accepted.
        while (q.size() < DEPTH) cyc(1'b1, 8'hC0 + DW'(q.size()), 1'b0);
        chk("full_before_rw", 32'(full_out), 32'd1);
        cyc(1'b1, 8'hEE, 1'b1);
        chk("full_rw_full", 32'(full_out), 32'd0);
        chk("full_rw_data", 32'(data_out), 32'h31);

        cyc(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 8'h99, 1'b1);
        rst = 1'b0;
        chk("mid_rst_empty", 32'(empty_out), 32'd1);
        chk("mid_rst_full", 32'(full_out), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'h00);
`ifdef FIFO_LEVEL_EN
        chk("mid_rst_level", 32'(level_out), 32'd0);
`endif
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_rd_ignored", 32'(data_out), 32'h00);

        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'hA0 + i), 1'b0);
        chk("five_empty", 32'(empty_out), 32'd0);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        chk("rst5_empty", 32'(empty_out), 32'd1);
        chk("rst5_full", 32'(full_out), 32'd0);
`ifdef FIFO_LEVEL_EN
        chk("rst5_level", 32'(level_out), 32'd0);
`endif
        cyc(1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
